// File: rtl/switch_pkg.sv
// Shared types and default constants for the switch sampling controller
// and the reusable tick prescaler.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        PUBLISH   = 2'd2
    } sw_state_e;

    localparam int SW_COUNT     = 10;
    localparam int TICK_DIV_1MS = 50000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: count 0..DIV-1, one-clk tick on the last count.
// Shared with the 7-seg refresh logic.
module tick_prescaler
    import switch_pkg::*;
#(
    parameter int DIV = TICK_DIV_1MS
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/switch_sample_ctrl.sv
// Synchronises, debounces and publishes switch changes over valid/ready.
// Optional macro SWITCH_SAMPLE_PULSE_EN adds the sw_commit_pulse output.
module switch_sample_ctrl
    import switch_pkg::*;
#(
    parameter int N_SW         = SW_COUNT,
    parameter int TICK_DIV     = TICK_DIV_1MS,
    parameter int STABLE_TICKS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] switches,
    output logic [N_SW-1:0] sw_value,
    output logic [N_SW-1:0] sw_changed,
    output logic            sw_valid,
    input  logic            sw_ready,
    output logic            busy
`ifdef SWITCH_SAMPLE_PULSE_EN
    ,
    output logic            sw_commit_pulse
`endif
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_TICKS);

    logic            tick;
    logic [N_SW-1:0] sync1_q, sync_q;
    logic [N_SW-1:0] cand_q, cand_d;
    logic [N_SW-1:0] committed_q, committed_d;
    logic [N_SW-1:0] changed_q, changed_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    sw_state_e       state_q, state_d;
    logic            commit;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        cand_d      = cand_q;
        committed_d = committed_q;
        changed_d   = changed_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && (sync_q != committed_q)) begin
                    if (STABLE_TICKS == 1) begin
                        commit = 1'b1;
                    end else begin
                        cand_d  = sync_q;
                        cnt_d   = CNT_ONE;
                        state_d = CANDIDATE;
                    end
                end
            end
            CANDIDATE: begin
                if (tick) begin
                    if (sync_q == committed_q) begin
                        state_d = IDLE;
                    end else if (sync_q != cand_q) begin
                        cand_d = sync_q;
                        cnt_d  = CNT_ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        commit = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PUBLISH: begin
                // Ticks landing on the accept edge are deliberately dropped.
                if (valid_q && sw_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // On every commit path sync_q already equals the candidate.
        if (commit) begin
            changed_d   = sync_q ^ committed_q;
            committed_d = sync_q;
            cand_d      = sync_q;
            valid_d     = 1'b1;
            state_d     = PUBLISH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync_q      <= '0;
            cand_q      <= '0;
            committed_q <= '0;
            changed_q   <= '0;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
        end else begin
            sync1_q     <= switches;
            sync_q      <= sync1_q;
            cand_q      <= cand_d;
            committed_q <= committed_d;
            changed_q   <= changed_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
        end
    end

    assign sw_value   = committed_q;
    assign sw_changed = changed_q;
    assign sw_valid   = valid_q;
    assign busy       = (state_q != IDLE);

`ifdef SWITCH_SAMPLE_PULSE_EN
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= commit;
        end
    end

    assign sw_commit_pulse = pulse_q;
`endif

endmodule
